// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative radix-2 multiply/divide sequencer for the execute stage.
// Runs MUL/MULHU/DIVU/REMU one bit per cycle on a shared shift/add/subtract datapath.
// It holds the pipeline with stall, then emits a one-cycle done pulse with the
// result and the destination register.
// Build option: define MULDIV_DIV_EN to include the restoring divider. Without it,
// DIVU/REMU complete in one cycle with result=0 and err=1.
module ex_muldiv_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [RD_W-1:0]   rd_out,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam int unsigned ACC_W = 2 * DATA_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              accept;
    logic              early_done;

    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [RD_W-1:0]   rd_q;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;

    logic [ACC_W-1:0]  mul_acc;
    logic [DATA_W-1:0] rem_nxt;
    logic              q_bit;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [ACC_W-1:0]  acc_nxt;
    logic [DATA_W-1:0] final_res;
    logic [DATA_W-1:0] early_res;

    // Pipeline hold: an op being accepted this cycle, or one in progress.
    assign stall = ((state == IDLE) && start && !flush) || (state == RUN);

    // State register.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, div-by-zero/unsupported ops skip RUN.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        early_done = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept = 1'b1;
                        if (op[1] && (!DIV_EN || (op_b == '0))) begin
                            early_done = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Multiplier step: MSB-first shift-add of the multiplicand into the product.
    always_comb begin
        mul_acc = (acc << 1) + (b_q[DATA_W-1] ? ACC_W'(a_q) : '0);
    end

`ifdef MULDIV_DIV_EN
    logic [DATA_W:0]   div_shift;
    logic              div_borrow;
    logic [DATA_W-1:0] div_diff;

    // Restoring divider step: shift in the next dividend bit, subtract if no borrow.
    always_comb begin
        div_shift  = {acc[DATA_W-1:0], a_q[DATA_W-1]};
        div_borrow = (div_shift < {1'b0, b_q});
        div_diff   = div_shift[DATA_W-1:0] - b_q;
        rem_nxt    = div_borrow ? div_shift[DATA_W-1:0] : div_diff;
        q_bit      = ~div_borrow;
    end
`else
    // Divider absent: the divide path carries constants.
    always_comb begin
        rem_nxt = '0;
        q_bit   = 1'b0;
    end
`endif

    // Per-iteration register update and final result selection.
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        acc_nxt   = acc;
        final_res = '0;
        if (op_q[1]) begin
            a_nxt   = {a_q[DATA_W-2:0], q_bit};
            acc_nxt = ACC_W'(rem_nxt);
        end else begin
            b_nxt   = b_q << 1;
            acc_nxt = mul_acc;
        end
        case (op_q)
            OP_MUL:   final_res = mul_acc[DATA_W-1:0];
            OP_MULHU: final_res = mul_acc[ACC_W-1:DATA_W];
            OP_DIVU:  final_res = a_nxt;
            OP_REMU:  final_res = rem_nxt;
            default:  final_res = '0;
        endcase
    end

    // One-cycle completion value: divide-by-zero convention or unsupported-op zero.
    always_comb begin
        early_res = '0;
        if (DIV_EN) begin
            early_res = op[0] ? op_a : '1;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (accept) begin
                op_q <= op;
                a_q  <= op_a;
                b_q  <= op_b;
                rd_q <= rd_in;
                cnt  <= '0;
                acc  <= '0;
                if (early_done) begin
                    result <= early_res;
                    err    <= 1'b1;
                    rd_out <= rd_in;
                end
            end else if ((state == RUN) && !flush) begin
                a_q <= a_nxt;
                b_q <= b_nxt;
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (state_next == DONE) begin
                    result <= final_res;
                    err    <= 1'b0;
                    rd_out <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl (DATA_W=32); expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    logic        sys_clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        er;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_res = 32'h0;

    ex_muldiv_ctrl #(.DATA_W(32), .RD_W(5)) dut (
        .sys_clock(sys_clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd_in    (rd_in),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out),
        .err      (err)
    );

    always #5 sys_clock = ~sys_clock;

    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected completion.
    always @(negedge sys_clock) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("rd_out", 32'(rd_out), 32'(e.rd));
                check("err", 32'(err), 32'(e.er));
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
                check("stall_in_done", 32'(stall), 32'h0);
            end
        end
    end

    // Issue one op at the current negedge, wait for its done, end at the next IDLE negedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input logic er,
                         input int lat);
        exp_t e;
        bit   seen;
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        rd_in = rd;
        e.res = res; e.rd = rd; e.er = er; e.issue = cyc; e.lat = lat;
        sb_q.push_back(e);
        last_res = res;
        #1;
        check("stall_accept", 32'(stall), 32'h1);
        @(negedge sys_clock);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("stall_run", 32'(stall), 32'h1);
            @(negedge sys_clock);
        end
        if (!seen) begin
            check("done_timeout", 32'(done), 32'h1);
        end
        @(negedge sys_clock);
    endtask

    initial begin
        int s;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'b00;
        op_a    = '0;
        op_b    = '0;
        rd_in   = '0;
        repeat (2) @(negedge sys_clock);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_rd_out", 32'(rd_out), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        reset_n = 1'b1;
        @(negedge sys_clock);

        // Multiply
        issue(2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 1'b0, 33);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0, 33);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 1'b0, 33);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0000_0000, 1'b0, 33);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 5'd7, 32'h0000_0001, 1'b0, 33);

        // Divide
        issue(2'b10, 32'd100, 32'd7, 5'd8, DIV ? 32'd14 : 32'd0, !DIV, DIV ? 33 : 1);
        issue(2'b11, 32'd100, 32'd7, 5'd9, DIV ? 32'd2 : 32'd0, !DIV, DIV ? 33 : 1);
        issue(2'b10, 32'hFFFF_FFFF, 32'd1, 5'd10, DIV ? 32'hFFFF_FFFF : 32'd0, !DIV, DIV ? 33 : 1);
        issue(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd11, DIV ? 32'hF : 32'd0, !DIV, DIV ? 33 : 1);
        issue(2'b10, 32'd3, 32'd7, 5'd12, 32'd0, !DIV, DIV ? 33 : 1);
        issue(2'b10, 32'd5, 32'd0, 5'd13, DIV ? 32'hFFFF_FFFF : 32'd0, 1'b1, 1);
        issue(2'b11, 32'd5, 32'd0, 5'd14, DIV ? 32'd5 : 32'd0, 1'b1, 1);

        // Start together with flush in IDLE is dropped
        start = 1'b1; flush = 1'b1; op = 2'b00; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
        #1;
        check("stall_start_flush", 32'(stall), 32'h0);
        @(negedge sys_clock);
        start = 1'b0; flush = 1'b0;
        check("busy_start_flush", 32'(busy), 32'h0);
        @(negedge sys_clock);

        // Flush in cycle 10 of a MUL, then a new start in cycle 11
        start = 1'b1; op = 2'b00; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd15;
        s = cyc;
        @(negedge sys_clock);
        start = 1'b0;
        repeat (9) @(negedge sys_clock);
        check("flush_cycle", 32'(cyc - s), 32'd10);
        flush = 1'b1;
        @(negedge sys_clock);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'h0);
        check("flush_done", 32'(done), 32'h0);
        check("flush_result_held", result, last_res);
        issue(2'b00, 32'd2, 32'd21, 5'd16, 32'd42, 1'b0, 33);

        // Reset in cycle 15 of a long op
        start = 1'b1; op = DIV ? 2'b10 : 2'b01; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd17;
        @(negedge sys_clock);
        start = 1'b0;
        repeat (14) @(negedge sys_clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_rd_out", 32'(rd_out), 32'h0);
        check("mid_rst_stall", 32'(stall), 32'h0);
        @(negedge sys_clock);
        reset_n = 1'b1;
        @(negedge sys_clock);
        issue(2'b00, 32'd3, 32'd4, 5'd18, 32'd12, 1'b0, 33);

        repeat (3) @(negedge sys_clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Iterative multiply/divide sequencer for the execute stage. It accepts one MUL/MULHU/DIVU/REMU operation from EX and runs it on a shared radix-2 shift/add/subtract datapath, one bit per cycle. While it works, it holds the pipeline with `stall`, then returns the result and destination register to the EX→ME boundary with a one-cycle `done` pulse. It sits beside the single-cycle ALU and owns the stall request for multi-cycle ops.

## Interface
Parameters:
- `DATA_W`, default 32: operand/result width; equals `VALUE_W`.
- `RD_W`, default 5: destination register address width; equals `REG_ADDR_W`.

Ports:
- `sys_clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  EX holds a mul/div op; sampled only in IDLE.
- `op`  in  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- `op_a`, `op_b`  in  DATA_W each  operands; multiplicand/dividend, multiplier/divisor.
- `rd_in`  in  RD_W  destination register.
- `flush`  in  1  abort the current op; highest priority after reset.
- `stall`  out  1  combinational: `(state==IDLE & start & ~flush) | state==RUN`.
- `busy`  out  1  registered: state != IDLE.
- `done`  out  1  registered one-cycle pulse; `result`, `rd_out`, `err` valid while high.
- `result`  out  DATA_W  product word, quotient or remainder; held until next accepted start.
- `rd_out`  out  RD_W  latched `rd_in`.
- `err`  out  1  qualified by `done`: divide-by-zero, or unsupported op.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start & ~flush`. Latch `op`, operands and `rd_in`; clear the iteration counter (width `$clog2(DATA_W)+1`) and the 2·DATA_W accumulator.
  - Divide ops with `op_b==0` go IDLE → DONE instead.
- RUN, one iteration per cycle; counter increments; after iteration DATA_W-1 → DONE.
  - Multiply: shift-add on a 2·DATA_W product register, unsigned. MUL returns bits [DATA_W-1:0], MULHU returns [2·DATA_W-1:DATA_W].
  - Divide: restoring. Shift remainder left by one and bring in the next dividend bit MSB-first. Subtract the divisor if no borrow; the quotient bit is the inverted borrow. DIVU returns the quotient, REMU the remainder.
- Divide-by-zero: DIVU result = all ones, REMU result = `op_a`, `err=1`.
- DONE: `done=1` for exactly one cycle, then → IDLE unconditionally. A `start` present in DONE is not accepted; it is sampled in the following IDLE cycle.
- `start` in RUN/DONE: ignored. Upstream is frozen by `stall` anyway.
- `flush` in any state → IDLE at the next edge. No `done` is produced; `result`/`rd_out` keep their previous values. `flush` together with `start` in IDLE: start is dropped.
- Reset: state IDLE, counter 0, `busy=0`, `done=0`, `err=0`, `result=0`, `rd_out=0`, accumulators 0. `stall` goes to 0 once `start` is removed. Reset mid-RUN abandons the op with no `done`.
- All arithmetic is unsigned, modulo 2^DATA_W on outputs; there is no overflow flag.

## Timing
- Cycle 0 = the cycle `start` is sampled high in IDLE.
- Normal op: RUN during cycles 1..DATA_W; `done` in cycle DATA_W+1. Latency is DATA_W+1 cycles; initiation interval is DATA_W+2.
- Divide-by-zero and unsupported op: `done` in cycle 1; latency 1.
- `stall` is high in cycles 0..DATA_W and low in the `done` cycle, so EX→ME captures `result` at the edge ending the `done` cycle.
- Back-to-back: the next start is accepted at cycle DATA_W+2 at the earliest.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath present; behaviour as above.
- `MULDIV_DIV_EN` undefined: the divide/subtract logic is not built. Ops 10/11 go IDLE → DONE with `result=0`, `err=1`, `done` in cycle 1, `rd_out` latched. MUL/MULHU are unchanged.

## Test plan
DATA_W=32 unless noted.
- MUL 7×6, `rd_in=3` → `stall` high cycles 0–32; `done` in cycle 33 with `result=42`, `rd_out=3`, `err=0`.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → `result=0xFFFFFFFE`. Same operands with MUL → `result=0x00000001`.
- DIVU 100/7 → `result=14`; REMU 100/7 → `result=2`. With the macro undefined, both give `result=0`, `err=1`, `done` in cycle 1.
- DIVU 5/0 → `done` in cycle 1, `result=0xFFFFFFFF`, `err=1`. REMU 5/0 → `result=5`.
- MUL started, `flush` in cycle 10 → `busy=0` in cycle 11, no `done` ever, `result` unchanged. A new start in cycle 11 completes normally in cycle 44.
- `reset_n` low in cycle 15 of a DIVU → all outputs at reset values immediately. After release, `start` with `op=00`, a=3, b=4 → `done` with `result=12`.
